vend_controller: RTL

VEND_CONTROLLER -- requirements
Module: vend_controller

---
 rtl/vend_controller_if.sv | 25 ++
 rtl/vend_controller.sv | 133 +++++++++++++
 2 files changed

// File: rtl/vend_controller_if.sv
// Vending controller bus: payment/selection/dispense inputs and the registered status outputs.
// master = machine front panel and dispenser, slave = vend_controller.
interface vend_controller_if;
   logic       coin;
   logic       refund;
   logic [1:0] sel_req;
   logic       disp_ack;
   logic [1:0] sel_gnt;
   logic       disp_req;
   logic       disp_slot;
   logic [2:0] credit;
   logic       coin_rej;
   logic       change_pulse;
   logic       fault;

   modport master (
      output coin, refund, sel_req, disp_ack,
      input  sel_gnt, disp_req, disp_slot, credit, coin_rej, change_pulse, fault
   );

   modport slave (
      input  coin, refund, sel_req, disp_ack,
      output sel_gnt, disp_req, disp_slot, credit, coin_rej, change_pulse, fault
   );
endinterface

// File: rtl/vend_controller.sv
// Coin-credit vending FSM with a timed dispense handshake, refund/change and a sticky fault.
// Define VEND_ROUND_ROBIN_EN for round-robin slot arbitration; otherwise slot 0 has fixed priority.
module vend_controller #(
   parameter int unsigned PRICE   = 3,
   parameter int unsigned TIMEOUT = 12
) (
   input logic              clk,
   input logic              rst,
   vend_controller_if.slave bus
);
   localparam int unsigned CW = 3;
   localparam int unsigned TW = 4;
   localparam logic [CW-1:0] CMAX    = 3'd7;
   localparam logic [CW-1:0] PRICE_C = CW'(PRICE);
   localparam logic [TW-1:0] TLAST   = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, GRANT, DISP, CHANGE, FAULT} state_t;

   state_t        state;
   logic [1:0]    rst_pipe;
   logic          rst_hold;
   logic [TW-1:0] tcnt;
   logic          drain;
   logic          gnt_slot;
   logic [CW-1:0] credit_inc;
   logic [CW:0]   restore_sum;

   // Release of rst is re-timed: the FSM stays frozen at reset values until the pipe drains.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rst_pipe <= 2'b11;
      else     rst_pipe <= {rst_pipe[0], 1'b0};
   end
   assign rst_hold = rst_pipe[1];

`ifdef VEND_ROUND_ROBIN_EN
   logic rr_ptr;  // slot preferred on the next contention

   always_comb begin
      gnt_slot = !bus.sel_req[0];
      if (bus.sel_req == 2'b11) gnt_slot = rr_ptr;
   end
`else
   always_comb begin
      gnt_slot = !bus.sel_req[0];
   end
`endif

   assign credit_inc  = bus.credit + CW'(bus.coin && (bus.credit != CMAX));
   assign restore_sum = {1'b0, bus.credit} + (CW+1)'(PRICE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         bus.credit       <= '0;
         bus.sel_gnt      <= '0;
         bus.disp_req     <= 1'b0;
         bus.disp_slot    <= 1'b0;
         bus.coin_rej     <= 1'b0;
         bus.change_pulse <= 1'b0;
         bus.fault        <= 1'b0;
         tcnt             <= '0;
         drain            <= 1'b0;
`ifdef VEND_ROUND_ROBIN_EN
         rr_ptr           <= 1'b0;
`endif
      end else if (!rst_hold) begin
         bus.sel_gnt      <= '0;
         bus.coin_rej     <= bus.coin;
         bus.change_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.refund && (bus.credit != '0)) begin
                  state <= CHANGE;
               end else begin
                  bus.coin_rej <= bus.coin && (bus.credit == CMAX);
                  if ((bus.sel_req != '0) && (bus.credit >= PRICE_C)) begin
                     state         <= GRANT;
                     bus.sel_gnt   <= gnt_slot ? 2'b10 : 2'b01;
                     bus.disp_slot <= gnt_slot;
                     bus.credit    <= credit_inc - PRICE_C;
`ifdef VEND_ROUND_ROBIN_EN
                     rr_ptr        <= !gnt_slot;
`endif
                  end else begin
                     bus.credit <= credit_inc;
                  end
               end
            end
            GRANT: begin
               state        <= DISP;
               bus.disp_req <= 1'b1;
               tcnt         <= '0;
            end
            DISP: begin
               // An ack on the final timeout cycle still counts as a delivery.
               if (bus.disp_ack) begin
                  bus.disp_req <= 1'b0;
                  state        <= (bus.credit != '0) ? CHANGE : IDLE;
               end else if (tcnt == TLAST) begin
                  bus.disp_req <= 1'b0;
                  bus.fault    <= 1'b1;
                  state        <= FAULT;
                  bus.credit   <= restore_sum[CW] ? CMAX : restore_sum[CW-1:0];
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            CHANGE: begin
               if (bus.credit != '0) begin
                  bus.change_pulse <= 1'b1;
                  bus.credit       <= bus.credit - CW'(1);
               end else begin
                  state <= IDLE;
               end
            end
            FAULT: begin
               // Terminal until rst; refund still pays out the restored credit.
               if (drain) begin
                  if (bus.credit != '0) begin
                     bus.change_pulse <= 1'b1;
                     bus.credit       <= bus.credit - CW'(1);
                  end else begin
                     drain <= 1'b0;
                  end
               end else if (bus.refund && (bus.credit != '0)) begin
                  drain <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
